// File: rtl/ifu_fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory, decoder and execute redirect.
// The master side is the fetch unit; the slave side is everything around it.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_misalign;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data,
    output inst_valid, inst, inst_pc, fetch_misalign,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data,
    input  inst_valid, inst, inst_pc, fetch_misalign,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> HOLD with redirect handling.
// Optional IFU_MISALIGN_CHK_EN turns misaligned PCs into fault entries instead of fetches.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] inst_q, inst_n;
  logic [XLEN-1:0] inst_pc_q, inst_pc_n;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q, misalign_n;
  logic pc_misaligned;
  assign pc_misaligned = (pc[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      inst_q    <= NOP;
      inst_pc_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop      <= drop_n;
      inst_q    <= inst_n;
      inst_pc_q <= inst_pc_n;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q <= misalign_n;
`endif
    end
  end

  // Redirect is tested first in every state so it outranks handshakes and responses.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    drop_n    = drop;
    inst_n    = inst_q;
    inst_pc_n = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_n = misalign_q;
`endif
    case (state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_n = bus.redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
        end else if (pc_misaligned) begin
          state_n    = S_HOLD;
          inst_n     = '0;
          inst_pc_n  = pc;
          misalign_n = 1'b1;
`endif
        end else if (bus.mem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response landing in the redirect cycle completes the old request, so no drop is owed.
        if (bus.redirect_valid) begin
          pc_n = bus.redirect_pc;
          if (bus.mem_resp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n = 1'b1;
          end
        end else if (bus.mem_resp_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            state_n   = S_HOLD;
            inst_n    = bus.mem_resp_data;
            inst_pc_n = pc;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_n = 1'b0;
`endif
          end
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_n    = bus.redirect_pc;
          state_n = S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
          misalign_n = 1'b0;
`endif
        end else if (bus.inst_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
          misalign_n = 1'b0;
`endif
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  // mem_req_valid is gated by rst_n so it drops immediately when reset asserts.
  always_comb begin
    bus.mem_req_valid = rst_n && (state == S_REQ);
`ifdef IFU_MISALIGN_CHK_EN
    if (pc_misaligned) begin
      bus.mem_req_valid = 1'b0;
    end
    bus.fetch_misalign = misalign_q;
`else
    bus.fetch_misalign = 1'b0;
`endif
    bus.mem_req_addr = pc;
    bus.inst_valid   = (state == S_HOLD);
    bus.inst         = inst_q;
    bus.inst_pc      = inst_pc_q;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: PC value loaded on reset.
REQ-002 Parameter XLEN, default 32: width of PC, address and instruction data.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 mem_req_valid  output  1: fetch request to instruction memory is valid.
REQ-006 mem_req_ready  input  1: memory accepts the request this cycle.
REQ-007 mem_req_addr  output  XLEN: fetch address, equals current PC.
REQ-008 mem_resp_valid  input  1: instruction word returned this cycle; memory has no backpressure.
REQ-009 mem_resp_data  input  XLEN: returned instruction word.
REQ-010 inst_valid  output  1: instruction offered to the decoder.
REQ-011 inst_ready  input  1: decoder consumes the offered instruction.
REQ-012 inst  output  XLEN: instruction word for the decoder.
REQ-013 inst_pc  output  XLEN: PC of the offered instruction.
REQ-014 redirect_valid  input  1: control-flow change from execute.
REQ-015 redirect_pc  input  XLEN: target PC for a redirect.
REQ-016 fetch_misalign  output  1: offered entry is a misaligned-PC fault; meaningful only with the macro in REQ-030.

Function
REQ-017 The FSM SHALL have states REQ, WAIT and HOLD, with REQ entered from reset.
REQ-018 REQ: assert mem_req_valid with mem_req_addr = pc; go to WAIT on mem_req_valid && mem_req_ready.
REQ-019 WAIT: on mem_resp_valid, latch mem_resp_data into inst and pc into inst_pc; go to HOLD.
REQ-020 HOLD: assert inst_valid; on inst_ready, set pc to pc+4 (modulo 2^XLEN, 32'hFFFF_FFFC wraps to 0) and go to REQ.
REQ-021 Minimum latency SHALL be request accepted in cycle N, response in N+1, inst_valid in N+2.
REQ-022 inst and inst_pc SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-023 At most one memory request SHALL be outstanding, and mem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-024 Redirect in REQ SHALL set pc to redirect_pc and keep the FSM in REQ; the new address is presented next cycle and any same-cycle handshake is treated as not having occurred.
REQ-025 Redirect in WAIT SHALL set pc to redirect_pc and set a drop flag; the next response is discarded, the flag cleared and the FSM goes to REQ; a response in the redirect cycle itself is discarded.
REQ-026 Redirect in HOLD SHALL drop the held instruction even if inst_ready=1, set pc to redirect_pc and go to REQ; inst_valid is 0 from the next cycle.
REQ-027 Redirect SHALL take priority over every other event in the same cycle.

Reset
REQ-028 While rst_n=0, outputs SHALL be asynchronously forced to: pc=RESET_PC, state=REQ, drop flag=0, inst=32'h0000_0013 (nop), inst_pc=0, inst_valid=0, fetch_misalign=0, mem_req_valid=0.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request; a response arriving after reset release without a new request SHALL be ignored.

Configuration
REQ-030 With IFU_MISALIGN_CHK_EN defined, REQ with pc[1:0]!=0 SHALL issue no memory request and go directly to HOLD with inst=0, inst_pc=pc and fetch_misalign=1; the entry is consumed or redirected like a normal instruction.
REQ-031 Without IFU_MISALIGN_CHK_EN, fetch_misalign SHALL be tied to 0 and misaligned PCs are fetched unmodified.

Verification
REQ-032 Reset release, mem_req_ready=1, response next cycle with 32'h0010_0093, inst_ready=1 -> mem_req_addr=32'h8000_0000, inst=32'h0010_0093, inst_pc=32'h8000_0000, then next request at 32'h8000_0004.
REQ-033 inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc unchanged, mem_req_valid=0 throughout.
REQ-034 redirect_valid=1 with redirect_pc=32'h8000_0100 in WAIT, then response 32'hDEAD_BEEF -> DEADBEEF never offered, next request at 32'h8000_0100.
REQ-035 redirect_valid=1 and inst_ready=1 together in HOLD -> held instruction dropped, next mem_req_addr=redirect_pc, not pc+4.
REQ-036 Macro defined, redirect_pc=32'h8000_0002 -> no mem_req_valid, inst_valid=1 with fetch_misalign=1 and inst_pc=32'h8000_0002.
REQ-037 rst_n pulsed low in WAIT, then stale response -> state REQ, pc=32'h8000_0000, inst_valid stays 0.
